// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the multiply/divide sequencer.
//   state_e       - sequencer FSM states
//   ALU_ADD/SUB/SLT - opcodes understood by the shared 32-bit ALU
//   ITER_DEFAULT  - default iteration count (operand width)
//   CNT_W         - iteration counter width
package mdu_pkg;

  localparam int ITER_DEFAULT = 32;
  localparam int CNT_W        = 6;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_DIV_CMP,
    S_DIV_SUB,
    S_FIN
  } state_e;

endpackage

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative unsigned MULTU/DIVU sequencer that borrows an
// external 32-bit ALU (add, sub, unsigned set-less-than).
// Ports:
//   clk, rstN            - clock, async active-low reset
//   start, isDiv         - one-cycle request and operation select (IDLE only)
//   opA, opB             - operands, sampled with start
//   aluResult            - result returned by the shared ALU
//   aluInA, aluInB, aluOp - operands/opcode driven to the shared ALU
//   busy, done           - operation in flight / one-cycle completion pulse
//   hi, lo, divByZero    - results; held until the next accepted start
//
// state      | meaning
// S_IDLE     | waiting for start
// S_MULT     | one shift-add step per cycle
// S_DIV_CMP  | compare shifted remainder against divisor
// S_DIV_SUB  | conditionally subtract, shift quotient bit in
// S_FIN      | publish results, pulse done on exit
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        start,
  input  logic        isDiv,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic [31:0] aluResult,
  output logic [31:0] aluInA,
  output logic [31:0] aluInB,
  output logic [2:0]  aluOp,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        divByZero
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        rem_q, rem_d, quo_q, quo_d;
  logic [31:0]        divisor_q, divisor_d;
  logic               is_div_q, is_div_d;
  logic               bit_out_q, bit_out_d;
  logic               lt_q, lt_d;
  logic               dbz_pend_q, dbz_pend_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [31:0]        rem_sh;
  logic               carry;

  // Shifted remainder used by both divide phases; quo is only shifted in
  // DIV_SUB, so quo_q[31] is still the next dividend bit in both.
  assign rem_sh = {rem_q[30:0], quo_q[31]};
  // The ALU only returns 32 bits; a wrapped sum is smaller than an addend.
  assign carry  = (aluResult < hi_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    divisor_d  = divisor_q;
    is_div_d   = is_div_q;
    bit_out_d  = bit_out_q;
    lt_d       = lt_q;
    dbz_pend_d = dbz_pend_q;
    dbz_d      = dbz_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    aluOp      = ALU_ADD;
    aluInA     = '0;
    aluInB     = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          divisor_d  = opB;
          cnt_d      = CNT_W'(ITER);
          busy_d     = 1'b1;
          dbz_d      = 1'b0;
          dbz_pend_d = 1'b0;
          is_div_d   = isDiv;
          if (!isDiv) begin
            hi_d    = '0;
            lo_d    = opA;
            state_d = S_MULT;
          end else if (opB == 32'd0) begin
            // Results staged in rem/quo so FIN publishes them like a normal divide.
            rem_d      = opA;
            quo_d      = '1;
            dbz_pend_d = 1'b1;
            state_d    = S_FIN;
          end else begin
            rem_d   = '0;
            quo_d   = opA;
            state_d = S_DIV_CMP;
          end
        end
      end

      S_MULT: begin
        aluOp  = ALU_ADD;
        aluInA = hi_q;
        aluInB = divisor_q;
        if (lo_q[0]) begin
          hi_d = {carry, aluResult[31:1]};
          lo_d = {aluResult[0], lo_q[31:1]};
        end else begin
          hi_d = {1'b0, hi_q[31:1]};
          lo_d = {hi_q[0], lo_q[31:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIN;
      end

      S_DIV_CMP: begin
        aluOp     = ALU_SLT;
        aluInA    = rem_sh;
        aluInB    = divisor_q;
        bit_out_d = rem_q[31];
        lt_d      = aluResult[0];
        state_d   = S_DIV_SUB;
      end

      S_DIV_SUB: begin
        aluOp  = ALU_SUB;
        aluInA = rem_sh;
        aluInB = divisor_q;
        // bit_out means the shifted remainder overflowed 32 bits, so it is
        // certainly >= divisor even though the 32-bit compare said otherwise.
        if (bit_out_q || !lt_q) begin
          rem_d = aluResult;
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = (cnt_q == CNT_W'(1)) ? S_FIN : S_DIV_CMP;
      end

      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        if (is_div_q) begin
          hi_d  = rem_q;
          lo_d  = quo_q;
          dbz_d = dbz_pend_q;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      is_div_q   <= 1'b0;
      bit_out_q  <= 1'b0;
      lt_q       <= 1'b0;
      dbz_pend_q <= 1'b0;
      dbz_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      divisor_q  <= divisor_d;
      is_div_q   <= is_div_d;
      bit_out_q  <= bit_out_d;
      lt_q       <= lt_d;
      dbz_pend_q <= dbz_pend_d;
      dbz_q      <= dbz_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign divByZero = dbz_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed + random checks of mdu_sequencer against a
// plain-arithmetic reference (64-bit product, / and %), with a behavioural
// model of the shared ALU.
module tb_mdu_sequencer;

  localparam int ITER = 32;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0;
  logic        isDiv = 1'b0;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic [31:0] aluResult;
  logic [31:0] aluInA, aluInB;
  logic [2:0]  aluOp;
  logic        busy, done, divByZero;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_err = 0;

  mdu_sequencer #(.ITER(ITER)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .start     (start),
    .isDiv     (isDiv),
    .opA       (opA),
    .opB       (opB),
    .aluResult (aluResult),
    .aluInA    (aluInA),
    .aluInB    (aluInB),
    .aluOp     (aluOp),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .divByZero (divByZero)
  );

  always #5 clk = ~clk;

  // Shared ALU as the parent would provide it.
  always_comb begin
    case (aluOp)
      3'b000:  aluResult = aluInA + aluInB;
      3'b001:  aluResult = aluInA - aluInB;
      3'b100:  aluResult = {31'd0, (aluInA < aluInB)};
      default: aluResult = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, optionally pulse a stray start inj cycles in,
  // and check latency, results, pulse width and hold behaviour.
  task automatic run_op(input string tag, input bit div, input logic [31:0] a,
                        input logic [31:0] b, input int inj);
    logic [63:0] prod;
    logic [31:0] exp_hi, exp_lo;
    logic        exp_dbz;
    int          exp_lat, lat;

    if (!div) begin
      prod    = 64'(a) * 64'(b);
      exp_hi  = prod[63:32];
      exp_lo  = prod[31:0];
      exp_dbz = 1'b0;
      exp_lat = ITER + 1;
    end else if (b == 32'd0) begin
      exp_hi  = a;
      exp_lo  = 32'hFFFF_FFFF;
      exp_dbz = 1'b1;
      exp_lat = 1;
    end else begin
      exp_hi  = a % b;
      exp_lo  = a / b;
      exp_dbz = 1'b0;
      exp_lat = 2 * ITER + 1;
    end

    @(negedge clk);
    start = 1'b1; isDiv = div; opA = a; opB = b;
    @(posedge clk);
    #1 start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < 200) begin
      if (lat == inj) begin
        start = 1'b1; isDiv = 1'b1; opA = 32'h1234_5678; opB = 32'd0;
      end
      @(posedge clk);
      #1 start = 1'b0;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    chk({tag, "_dbz"}, 64'(divByZero), 64'(exp_dbz));
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 64'(done), 64'd0);
    chk({tag, "_hold"}, {hi, lo}, {exp_hi, exp_lo});
    chk({tag, "_idle_alu"}, {29'd0, aluOp, aluInA}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_flags", {61'd0, busy, done, divByZero}, 64'd0);
    chk("rst_alu", {29'd0, aluOp, aluInA}, 64'd0);
    rstN = 1'b1;

    run_op("mul6x7", 1'b0, 32'd6, 32'd7, -1);
    run_op("mulmax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op("div100_7", 1'b1, 32'd100, 32'd7, -1);
    run_op("divmax_1", 1'b1, 32'hFFFF_FFFF, 32'd1, -1);
    run_op("divbig", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, -1);
    run_op("mul_inj", 1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 10);
    run_op("div_inj", 1'b1, 32'd1000, 32'd3, 30);
    run_op("dbz5", 1'b1, 32'd5, 32'd0, -1);

    // Reset in the middle of a divide discards it.
    @(negedge clk);
    start = 1'b1; isDiv = 1'b1; opA = 32'd999; opB = 32'd13;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rstN = 1'b0;
    #1;
    chk("mid_rst_hilo", {hi, lo}, 64'd0);
    chk("mid_rst_flags", {61'd0, busy, done, divByZero}, 64'd0);
    chk("mid_rst_alu", {29'd0, aluOp, aluInA}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (done) chk("rst_no_done", 64'(done), 64'd0);
    end
    chk("rst_still_idle", 64'(busy), 64'd0);
    run_op("mul3x4", 1'b0, 32'd3, 32'd4, -1);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op("rmul", 1'b0, ra, rb, -1);
    end
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom_range(1, 255) : $urandom;
      if (rb == 32'd0) rb = 32'd1;
      run_op("rdiv", 1'b1, ra, rb, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 Parameter: ITER, default 32, iteration count, equal to the operand width.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rstN  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin an operation; sampled only in IDLE.
REQ-005 isDiv  input  1  0 = unsigned multiply (MULTU), 1 = unsigned divide (DIVU); sampled with start.
REQ-006 opA  input  32  multiplicand or dividend; sampled with start.
REQ-007 opB  input  32  multiplier or divisor; sampled with start.
REQ-008 aluResult  input  32  result from the shared ALU.
REQ-009 aluInA, aluInB  output  32 each  operands driven to the shared ALU.
REQ-010 aluOp  output  3  ALU opcode: 000 add, 001 sub, 100 unsigned set-less-than.
REQ-011 busy  output  1  high from the cycle after start is accepted until done.
REQ-012 done  output  1  one-cycle pulse; hi/lo are valid from this cycle onward.
REQ-013 hi, lo  output  32 each  MULTU: {hi,lo} = 64-bit product; DIVU: lo = quotient, hi = remainder.
REQ-014 divByZero  output  1  set with done when DIVU had opB = 0; cleared on the next accepted start.

Function
REQ-015 States: IDLE, MULT, DIV_CMP, DIV_SUB, FIN; a 6-bit iteration counter is loaded with ITER on accept.
REQ-016 IDLE with start=1: latch opB; MULT path sets hi=0, lo=opA; DIV path sets rem=0, quo=opA; go to MULT, or to DIV_CMP when isDiv=1.
REQ-017 start in any state other than IDLE is ignored and has no effect on the state, registers or outputs.
REQ-018 MULT: aluOp=000, aluInA=hi, aluInB=latched opB.
REQ-018a MULT, lo[0]=1: carry = (aluResult < hi, unsigned), then {hi,lo} <= {carry,aluResult,lo} >> 1.
REQ-018b MULT, lo[0]=0: {hi,lo} <= {1'b0,hi,lo} >> 1.
REQ-018c MULT: decrement counter each cycle; after ITER cycles go to FIN.
REQ-019 DIV_CMP: form rem' = {rem[30:0], quo[31]}; drive aluOp=100, aluInA=rem', aluInB=divisor.
REQ-019a DIV_CMP: record bitOut = rem[31] and lt = aluResult[0]; go to DIV_SUB.
REQ-020 DIV_SUB: aluOp=001, aluInA=rem', aluInB=divisor.
REQ-020a DIV_SUB, bitOut=1 or lt=0: rem <= aluResult and quo <= {quo[30:0],1}.
REQ-020b DIV_SUB, otherwise: rem <= rem' and quo <= {quo[30:0],0}.
REQ-020c DIV_SUB: decrement counter; counter 0 -> FIN, else -> DIV_CMP.
REQ-021 Divide by zero: DIVU accept with opB=0 goes directly to FIN; hi=opA, lo=32'hFFFFFFFF, divByZero=1.
REQ-022 FIN: done=1 for exactly one cycle; DIV copies quo->lo and rem->hi; return to IDLE.
REQ-023 Latency from the accepting edge to done high: MULTU ITER+1 cycles (33), DIVU 2*ITER+1 cycles (65), divide by zero 1 cycle.
REQ-024 The cycle after done, a new start is accepted; back-to-back operations are supported.
REQ-025 In IDLE and FIN: aluOp=000, aluInA=0, aluInB=0.
REQ-026 hi, lo and divByZero hold their values until the next accepted start.
REQ-027 All arithmetic is unsigned; the ALU is used only in 32-bit mode; any carry or borrow is reconstructed locally as specified.

Reset
REQ-028 rstN low, at any time including mid-operation: state=IDLE, counter=0, busy=0, done=0, divByZero=0, hi=0, lo=0, internal rem/quo/divisor=0.
REQ-029 An operation interrupted by reset is discarded; no done pulse is produced for it.
REQ-030 First start is accepted on the first rising edge after rstN is released.

Structure
REQ-031 Package mdu_pkg holds the state enum, the ALU opcode constants ALU_ADD/ALU_SUB/ALU_SLT, and the default ITER.
REQ-032 The ALU is instantiated by the parent, not inside mdu_sequencer.
REQ-033 No sub-module: the counter and local carry compare are inline.

Verification
REQ-034 MULTU opA=6, opB=7 -> done at cycle 33, hi=0, lo=42, divByZero=0.
REQ-035 MULTU opA=opB=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 (exercises carry).
REQ-036 DIVU 100/7 -> done at cycle 65, lo=14, hi=2; DIVU 32'hFFFFFFFF/1 -> lo=32'hFFFFFFFF, hi=0.
REQ-037 DIVU opB=0, opA=5 -> done one cycle after accept, hi=5, lo=32'hFFFFFFFF, divByZero=1.
REQ-038 start pulsed at cycle 10 of a MULTU -> ignored, original result correct; start the cycle after done -> accepted.
REQ-039 rstN low at cycle 20 of a DIVU -> all outputs 0 immediately, no done; next MULTU 3*4 -> lo=12.
